// File: rtl/dm_responder.sv
// Data-memory responder for the CPU M-stage data port, with a write-trace FIFO.
// Optional: define DM_DISPLAY_EN to print every in-range committed write.
module dm_responder #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LOG_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic [3:0]  log_byteen,
  output logic [31:0] log_pc,
  output logic        log_overflow,
  output logic [15:0] oob_count
);

  localparam int unsigned WORDS = 1 << ADDR_W;
  localparam int unsigned PTR_W = $clog2(LOG_DEPTH);
  localparam int unsigned CNT_W = $clog2(LOG_DEPTH + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  byteen;
    logic [31:0] pc;
  } logEntry_t;

  logic [31:0]            mem [WORDS];
  logic [WORDS-1:0]       wordValid;
  logic [ADDR_W-1:0]      index;
  logic                   inRange;
  logic                   wrReq;
  logic                   doWrite;
  logic                   oobWrite;
  logic [31:0]            oldWord;
  logic [31:0]            mergedWord;
  logic [31:0]            wordAddr;
  logic [1:0]             unusedAddrBits;

  logEntry_t [LOG_DEPTH-1:0] fifo;
  logEntry_t                 head;
  logic [PTR_W-1:0]          wrPtr;
  logic [PTR_W-1:0]          rdPtr;
  logic [CNT_W-1:0]          occupancy;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      pop;

  assign unusedAddrBits = m_data_addr[1:0];
  assign index          = m_data_addr[ADDR_W+1:2];
  assign inRange        = (m_data_addr[31:ADDR_W+2] == '0);
  assign wrReq          = |m_data_byteen;
  assign doWrite        = wrReq && inRange;
  assign oobWrite       = wrReq && !inRange;
  assign wordAddr       = {{(30-ADDR_W){1'b0}}, index, 2'b00};

  // Whole-memory clear is a per-word valid bit: a cleared word reads as zero
  // until its next write, so the array itself needs no reset path.
  assign oldWord      = wordValid[index] ? mem[index] : '0;
  assign m_data_rdata = inRange ? oldWord : '0;

  always_comb begin
    mergedWord = oldWord;
    for (int unsigned k = 0; k < 4; k++) begin
      if (m_data_byteen[k]) begin
        mergedWord[8*k +: 8] = m_data_wdata[8*k +: 8];
      end
    end
  end

  assign empty = (occupancy == '0);
  assign full  = (occupancy == CNT_W'(LOG_DEPTH));
  assign pop   = log_ready && !empty;
  assign push  = doWrite && (!full || pop);

  assign head       = fifo[rdPtr];
  assign log_valid  = !empty;
  assign log_addr   = head.addr;
  assign log_data   = head.data;
  assign log_byteen = head.byteen;
  assign log_pc     = head.pc;

  always_ff @(posedge clk) begin
    if (!reset && doWrite) begin
      mem[index] <= mergedWord;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wordValid    <= '0;
      fifo         <= '0;
      wrPtr        <= '0;
      rdPtr        <= '0;
      occupancy    <= '0;
      log_overflow <= 1'b0;
      oob_count    <= '0;
    end else begin
      if (doWrite) begin
        wordValid[index] <= 1'b1;
      end
      if (oobWrite && oob_count != '1) begin
        oob_count <= oob_count + 16'd1;
      end
      if (push) begin
        fifo[wrPtr] <= '{addr: wordAddr, data: mergedWord,
                         byteen: m_data_byteen, pc: m_inst_addr};
        wrPtr       <= wrPtr + PTR_W'(1);
      end
      if (doWrite && !push) begin
        log_overflow <= 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef DM_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!reset && doWrite) begin
      $display("%d@%h: *%h <= %h", $time, m_inst_addr, wordAddr, mergedWord);
    end
  end
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed, table-driven self-checking bench for dm_responder (default parameters).
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic [3:0]  log_byteen;
  logic [31:0] log_pc;
  logic        log_overflow;
  logic [15:0] oob_count;

  int errors = 0;
  int checks = 0;

  dm_responder #(.ADDR_W(12), .LOG_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
    .m_data_rdata(m_data_rdata),
    .log_valid(log_valid), .log_ready(log_ready),
    .log_addr(log_addr), .log_data(log_data), .log_byteen(log_byteen),
    .log_pc(log_pc), .log_overflow(log_overflow), .oob_count(oob_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] pc;
    logic [31:0] expBefore;
    logic [31:0] expAfter;
    logic [15:0] expOob;
    logic        expValid;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be, input logic [31:0] pc);
    m_data_addr = a; m_data_wdata = d; m_data_byteen = be; m_inst_addr = pc;
    tick();
    m_data_byteen = 4'b0000;
  endtask

  task automatic rdCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
    m_data_addr = a; m_data_byteen = 4'b0000;
    #1;
    check(name, m_data_rdata, exp);
  endtask

  task automatic popCheck(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [31:0] pc);
    check({name, ".valid"}, {31'b0, log_valid}, 32'd1);
    check({name, ".addr"}, log_addr, a);
    check({name, ".data"}, log_data, d);
    check({name, ".byteen"}, {28'b0, log_byteen}, {28'b0, be});
    check({name, ".pc"}, log_pc, pc);
    log_ready = 1'b1;
    tick();
    log_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; log_ready = 1'b0;
    m_data_addr = '0; m_data_wdata = '0; m_data_byteen = '0; m_inst_addr = '0;

    vecs[0] = '{32'h0000_0004, 32'h1234_5678, 4'b1111, 32'h3000, 32'h0,          32'h1234_5678, 16'd0, 1'b1};
    vecs[1] = '{32'h0000_0005, 32'h0000_AB00, 4'b0010, 32'h3004, 32'h1234_5678, 32'h1234_AB78, 16'd0, 1'b1};
    vecs[2] = '{32'h0001_0000, 32'hDEAD_BEEF, 4'b1111, 32'h3008, 32'h0,          32'h0,          16'd1, 1'b1};
    vecs[3] = '{32'h0001_0000, 32'h0,          4'b0000, 32'h300C, 32'h0,          32'h0,          16'd1, 1'b1};
    vecs[4] = '{32'h0000_0008, 32'hAABB_CCDD, 4'b1001, 32'h3010, 32'h0,          32'hAA00_00DD, 16'd1, 1'b1};
    vecs[5] = '{32'h0000_3FFC, 32'hCAFE_F00D, 4'b1111, 32'h3014, 32'h0,          32'hCAFE_F00D, 16'd1, 1'b1};
    vecs[6] = '{32'h0000_4000, 32'h1111_1111, 4'b0001, 32'h3018, 32'h0,          32'h0,          16'd2, 1'b1};

    tick(); tick();
    reset = 1'b0;

    rdCheck("reset.rdata", 32'h0000_0010, 32'h0);
    check("reset.valid", {31'b0, log_valid}, 32'd0);
    check("reset.oob", {16'b0, oob_count}, 32'd0);
    check("reset.overflow", {31'b0, log_overflow}, 32'd0);
    check("reset.logData", log_data, 32'h0);

    foreach (vecs[i]) begin
      m_data_addr = vecs[i].addr; m_data_wdata = vecs[i].wdata;
      m_data_byteen = vecs[i].byteen; m_inst_addr = vecs[i].pc;
      #1;
      check($sformatf("vec%0d.before", i), m_data_rdata, vecs[i].expBefore);
      tick();
      m_data_byteen = 4'b0000;
      #1;
      check($sformatf("vec%0d.after", i), m_data_rdata, vecs[i].expAfter);
      check($sformatf("vec%0d.oob", i), {16'b0, oob_count}, {16'b0, vecs[i].expOob});
      check($sformatf("vec%0d.valid", i), {31'b0, log_valid}, {31'b0, vecs[i].expValid});
    end

    popCheck("drain0", 32'h4, 32'h1234_5678, 4'b1111, 32'h3000);
    popCheck("drain1", 32'h4, 32'h1234_AB78, 4'b0010, 32'h3004);
    popCheck("drain2", 32'h8, 32'hAA00_00DD, 4'b1001, 32'h3010);
    popCheck("drain3", 32'h3FFC, 32'hCAFE_F00D, 4'b1111, 32'h3014);
    check("drain.empty", {31'b0, log_valid}, 32'd0);
    log_ready = 1'b1; tick(); log_ready = 1'b0;
    check("popEmpty.valid", {31'b0, log_valid}, 32'd0);
    check("popEmpty.overflow", {31'b0, log_overflow}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      wr(32'h100 + 32'(4*i), 32'h1000 + 32'(i), 4'b1111, 32'h4000 + 32'(4*i));
    end
    check("ovf.flag", {31'b0, log_overflow}, 32'd1);
    rdCheck("ovf.memWrite", 32'h120, 32'h1008);
    for (int i = 0; i < 8; i++) begin
      popCheck($sformatf("ovf%0d", i), 32'h100 + 32'(4*i), 32'h1000 + 32'(i),
               4'b1111, 32'h4000 + 32'(4*i));
    end
    check("ovf.empty", {31'b0, log_valid}, 32'd0);
    check("ovf.sticky", {31'b0, log_overflow}, 32'd1);

    reset = 1'b1; tick(); reset = 1'b0;
    check("rst2.overflow", {31'b0, log_overflow}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      wr(32'h200 + 32'(4*i), 32'h2000 + 32'(i), 4'b1111, 32'h5000 + 32'(4*i));
    end
    log_ready = 1'b1;
    wr(32'h240, 32'h2FFF, 4'b1111, 32'h5FFC);
    log_ready = 1'b0;
    check("fullPush.overflow", {31'b0, log_overflow}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      popCheck($sformatf("full%0d", i), 32'h200 + 32'(4*i), 32'h2000 + 32'(i),
               4'b1111, 32'h5000 + 32'(4*i));
    end
    popCheck("fullLast", 32'h240, 32'h2FFF, 4'b1111, 32'h5FFC);
    check("full.empty", {31'b0, log_valid}, 32'd0);

    wr(32'h10, 32'h0BAD_F00D, 4'b1111, 32'h6000);
    wr(32'h14, 32'h0BAD_F00E, 4'b1111, 32'h6004);
    wr(32'h8000_0000, 32'h1, 4'b1111, 32'h6008);
    check("preRst.oob", {16'b0, oob_count}, 32'd1);
    check("preRst.valid", {31'b0, log_valid}, 32'd1);
    reset = 1'b1;
    wr(32'h300, 32'h5555_5555, 4'b1111, 32'h600C);
    reset = 1'b0;
    rdCheck("rst.rd300", 32'h300, 32'h0);
    rdCheck("rst.rd200", 32'h200, 32'h0);
    rdCheck("rst.rd10", 32'h10, 32'h0);
    rdCheck("rst.rd3FFC", 32'h3FFC, 32'h0);
    check("rst.valid", {31'b0, log_valid}, 32'd0);
    check("rst.oob", {16'b0, oob_count}, 32'd0);
    check("rst.overflow", {31'b0, log_overflow}, 32'd0);
    check("rst.logAddr", log_addr, 32'h0);
    check("rst.logData", log_data, 32'h0);
    check("rst.logPc", log_pc, 32'h0);
    check("rst.logByteen", {28'b0, log_byteen}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the pipelined CPU's M-stage data port: the memory side of the m_data_addr / m_data_wdata / m_data_byteen / m_data_rdata interface.
- Asynchronous word read, byte-lane-masked synchronous write, out-of-range detection.
- Buffers every committed write in a trace FIFO that a checker drains over a valid/ready handshake.
- Sits beside the CPU core in the top level; replaces the bench-side DM model.

Parameters:
- ADDR_W, 12, word-address width; memory holds 2^ADDR_W 32-bit words (16 KiB default).
- LOG_DEPTH, 8, trace FIFO depth in entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- m_data_addr  in  32  byte address from CPU M stage
- m_data_wdata  in  32  write word, already lane-positioned by CPU
- m_data_byteen  in  4  byte-lane write enables; 4'b0000 = no write
- m_inst_addr  in  32  PC of the M-stage instruction, for tracing
- m_data_rdata  out  32  read word at word-aligned m_data_addr
- log_valid  out  1  trace FIFO non-empty
- log_ready  in  1  consumer accepts head entry
- log_addr  out  32  word-aligned byte address of head entry
- log_data  out  32  full word value after the write
- log_byteen  out  4  lanes written
- log_pc  out  32  PC of the storing instruction
- log_overflow  out  1  sticky: a write was dropped from the log
- oob_count  out  16  saturating count of out-of-range write attempts

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Index = m_data_addr[ADDR_W+1:2]; low two address bits ignored for indexing.
- In range: m_data_addr[31:ADDR_W+2] == 0.
- Read: combinational, same cycle.
  - m_data_rdata = mem[index] if in range, else 32'h0.
  - A write in cycle N is visible on m_data_rdata from cycle N+1; in cycle N the old word is returned.
- Write: on a rising edge with m_data_byteen != 0 and address in range, byte lane k (bits 8k+7:8k) takes m_data_wdata lane k. Other lanes keep their value.
- Out-of-range write (byteen != 0, not in range):
  - memory and log unchanged;
  - oob_count increments, saturating at 16'hFFFF.
  - Reads never count.
- Trace push: every in-range write pushes {index<<2, merged new word, byteen, m_inst_addr}. The merged word is old word with enabled lanes replaced.
- Trace pop: log_valid && log_ready at a rising edge removes the head. Head outputs are driven from the FIFO storage and are stable while log_valid is high and no pop occurs.
- Simultaneous push and pop, any occupancy: both happen; occupancy unchanged. When full, the push succeeds because a slot frees.
- Push when full, no pop: entry dropped, log_overflow set to 1. Memory write still happens. log_overflow clears only on reset.
- Pop when empty: ignored.
- Pointers wrap modulo LOG_DEPTH; occupancy counter is LOG_DEPTH+1 states wide so full and empty are distinguishable.
- Reset, including mid-stream:
  - all memory words 32'h0;
  - FIFO emptied: log_valid=0, log_addr/log_data/log_pc=0, log_byteen=0;
  - log_overflow=0, oob_count=0;
  - m_data_rdata reads 0 from the next cycle.
  - Writes presented in the reset cycle are discarded.

Optional Feature:
- Macro: DM_DISPLAY_EN.
- Defined: every in-range write prints, at the rising edge, "%d@%h: *%h <= %h" (time, m_inst_addr, word-aligned address, merged new word).
- Undefined: no display statements are compiled; functional behaviour is identical.

Test Plan:
- Reset, then read address 32'h0000_0010: m_data_rdata = 32'h0 and log_valid = 0.
- Write 32'h1234_5678 to 32'h0000_0004 with byteen 4'b1111 at PC 32'h0000_3000. Then write 32'h0000_AB00 to 32'h0000_0005 with byteen 4'b0010.
  - Read returns 32'h1234_AB78.
  - Log holds 2 entries: second is {32'h0000_0004, 32'h1234_AB78, 4'b0010}.
- Write 32'hDEAD_BEEF to 32'h0001_0000 (ADDR_W=12, out of range) with byteen 4'b1111:
  - oob_count = 1, log_valid unchanged;
  - reading that address returns 32'h0.
- log_ready=0, then perform 9 in-range writes (LOG_DEPTH=8):
  - 8 entries retained, the 9th dropped;
  - log_overflow = 1;
  - draining yields the first 8 in order.
- FIFO full, log_ready=1, write in the same cycle: occupancy stays 8, log_overflow stays 0, the new entry appears last.
- Fill memory and FIFO, assert reset for one cycle mid-write:
  - all reads = 0, log_valid = 0, oob_count = 0;
  - the write presented in the reset cycle is not stored.
